twiddle_fetch: RTL and testbench

TWIDDLE_FETCH -- requirements
Module: twiddle_fetch

---
 rtl/twiddle_fetch_pkg.sv | 16 +
 rtl/twiddle_fetch_fsm.sv | 83 ++++++++
 rtl/twiddle_fetch.sv | 129 ++++++++++++
 tb/tb_twiddle_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_fetch_pkg.sv
// Shared FFT definitions for the twiddle fetch block: default widths,
// FSM encoding and twiddle-per-stage constant.
package twiddle_fetch_pkg;

   localparam int unsigned DataWidth  = 16;
   localparam int unsigned AddrWidth  = 4;
   localparam int unsigned TwPerStage = 4;
   localparam int unsigned KWidth     = $clog2(TwPerStage);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StLoad  = 2'd2
   } fsm_state_e;

endpackage

// File: rtl/twiddle_fetch_fsm.sv
// Sequencer for the twiddle fetch: IDLE/FETCH/LOAD state plus the twiddle
// index (k) and pass counters that decide when the last twiddle is loaded.
module twiddle_fetch_fsm
   import twiddle_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              busy_i,
   input  logic [7:0]        passes_i,
   input  logic              tw_valid_i,
   input  logic              tw_ready_i,
   output logic              start_acc_o,
   output logic              load_o,
   output logic              last_o,
   output logic [KWidth-1:0] k_o,
   output logic [KWidth-1:0] k_next_o
);

   fsm_state_e        state_q, state_d;
   logic [KWidth-1:0] k_q, k_d;
   logic [7:0]        pass_q, pass_d;
   logic [7:0]        passes_q, passes_d;

   logic start_acc;
   logic load;
   logic last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         k_q      <= '0;
         pass_q   <= '0;
         passes_q <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         pass_q   <= pass_d;
         passes_q <= passes_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_acc) state_d = StFetch;
         StFetch: state_d = StLoad;
         StLoad:  if (load) state_d = last ? StIdle : StFetch;
         default: state_d = StIdle;
      endcase
   end

   // pass only advances on a k wrap, and the last twiddle is reached at
   // pass==passes, so the 8-bit pass counter never overflows.
   always_comb begin
      k_d      = k_q;
      pass_d   = pass_q;
      passes_d = passes_q;
      if (start_acc) begin
         k_d      = '0;
         pass_d   = '0;
         passes_d = passes_i;
      end else if (load && !last) begin
         k_d = k_q + KWidth'(1);
         if (k_q == KWidth'(TwPerStage - 1)) begin
            pass_d = pass_q + 8'd1;
         end
      end
   end

   always_comb begin
      start_acc = (state_q == StIdle) && start_i && !busy_i;
      load      = (state_q == StLoad) && (!tw_valid_i || tw_ready_i);
      last      = (k_q == KWidth'(TwPerStage - 1)) && (pass_q == passes_q);
   end

   assign start_acc_o = start_acc;
   assign load_o      = load;
   assign last_o      = last;
   assign k_o         = k_q;
   assign k_next_o    = k_q + KWidth'(1);

endmodule

// File: rtl/twiddle_fetch.sv
// Streams the twiddles of one FFT stage from an external registered ROM,
// repeated passes+1 times, through a valid/ready output register.
module twiddle_fetch
   import twiddle_fetch_pkg::*;
#(
   parameter int unsigned data_width    = DataWidth,
   parameter int unsigned address_width = AddrWidth
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [1:0]               stage,
   input  logic [7:0]               passes,
   output logic [address_width-1:0] rom_addr,
   input  logic [data_width-1:0]    rom_datar,
   input  logic [data_width-1:0]    rom_datai,
   output logic [data_width-1:0]    tw_r,
   output logic [data_width-1:0]    tw_i,
   output logic [1:0]               tw_k,
   output logic                     tw_last,
   output logic                     tw_valid,
   input  logic                     tw_ready,
   output logic                     busy,
   output logic                     done
);

   logic                     start_acc;
   logic                     load;
   logic                     last;
   logic [KWidth-1:0]        k;
   logic [KWidth-1:0]        k_next;

   logic [address_width-1:0] rom_addr_q, rom_addr_d;
   logic [1:0]               stage_q, stage_d;
   logic [data_width-1:0]    tw_r_q, tw_r_d;
   logic [data_width-1:0]    tw_i_q, tw_i_d;
   logic [1:0]               tw_k_q, tw_k_d;
   logic                     tw_last_q, tw_last_d;
   logic                     tw_valid_q, tw_valid_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   twiddle_fetch_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .busy_i      (busy_q),
      .passes_i    (passes),
      .tw_valid_i  (tw_valid_q),
      .tw_ready_i  (tw_ready),
      .start_acc_o (start_acc),
      .load_o      (load),
      .last_o      (last),
      .k_o         (k),
      .k_next_o    (k_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr_q <= '0;
         stage_q    <= '0;
         tw_r_q     <= '0;
         tw_i_q     <= '0;
         tw_k_q     <= '0;
         tw_last_q  <= 1'b0;
         tw_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         stage_q    <= stage_d;
         tw_r_q     <= tw_r_d;
         tw_i_q     <= tw_i_d;
         tw_k_q     <= tw_k_d;
         tw_last_q  <= tw_last_d;
         tw_valid_q <= tw_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      rom_addr_d = rom_addr_q;
      stage_d    = stage_q;
      tw_r_d     = tw_r_q;
      tw_i_d     = tw_i_q;
      tw_k_d     = tw_k_q;
      tw_last_d  = tw_last_q;
      tw_valid_d = tw_valid_q;
      busy_d     = busy_q;

      if (start_acc) begin
         stage_d    = stage;
         rom_addr_d = address_width'({stage, {KWidth{1'b0}}});
         busy_d     = 1'b1;
      end

      // A load may coincide with acceptance of the previous twiddle; the new
      // twiddle then replaces it without a valid bubble.
      if (load) begin
         tw_r_d     = rom_datar;
         tw_i_d     = rom_datai;
         tw_k_d     = k;
         tw_last_d  = last;
         tw_valid_d = 1'b1;
         if (!last) begin
            rom_addr_d = address_width'({stage_q, k_next});
         end
      end else if (tw_valid_q && tw_ready) begin
         tw_valid_d = 1'b0;
      end

      // busy covers the drain of the final twiddle, so it drops with done.
      done_d = tw_valid_q && tw_ready && tw_last_q;
      if (done_d) begin
         busy_d = 1'b0;
      end
   end

   assign rom_addr = rom_addr_q;
   assign tw_r     = tw_r_q;
   assign tw_i     = tw_i_q;
   assign tw_k     = tw_k_q;
   assign tw_last  = tw_last_q;
   assign tw_valid = tw_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Scoreboard bench for twiddle_fetch: a registered ROM model feeds the DUT,
// directed sequences push expected twiddles, a monitor checks accepted ones.
module tb_twiddle_fetch;

   typedef struct packed {
      logic [15:0] r;
      logic [15:0] i;
      logic [1:0]  k;
      logic        last;
   } tw_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  stage;
   logic [7:0]  passes;
   logic [3:0]  rom_addr;
   logic [15:0] rom_datar = '0;
   logic [15:0] rom_datai = '0;
   logic [15:0] tw_r;
   logic [15:0] tw_i;
   logic [1:0]  tw_k;
   logic        tw_last;
   logic        tw_valid;
   logic        tw_ready;
   logic        busy;
   logic        done;

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   tw_t  sb[$];

   twiddle_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stage     (stage),
      .passes    (passes),
      .rom_addr  (rom_addr),
      .rom_datar (rom_datar),
      .rom_datai (rom_datai),
      .tw_r      (tw_r),
      .tw_i      (tw_i),
      .tw_k      (tw_k),
      .tw_last   (tw_last),
      .tw_valid  (tw_valid),
      .tw_ready  (tw_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Hand-entered twiddle table, {real, imag}.
   function automatic logic [31:0] rom_word(input logic [3:0] a);
      case (a)
         4'd5:    return 32'h7641_CF05;
         4'd6:    return 32'h5A82_A57E;
         4'd7:    return 32'h30FB_89BF;
         4'd9:    return 32'h30FB_89BF;
         4'd10:   return 32'hA57E_A57E;
         4'd11:   return 32'h89BF_30FB;
         default: return 32'h7FFF_0000;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [31:0] w;
      w = rom_word(rom_addr);
      rom_datar <= w[31:16];
      rom_datai <= w[15:0];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_seq(input logic [1:0] s, input logic [7:0] p);
      tw_t         e;
      logic [31:0] w;
      for (int ps = 0; ps <= int'(p); ps++) begin
         for (int kk = 0; kk < 4; kk++) begin
            w      = rom_word({s, 2'(kk)});
            e.r    = w[31:16];
            e.i    = w[15:0];
            e.k    = 2'(kk);
            e.last = (kk == 3) && (ps == int'(p));
            sb.push_back(e);
         end
      end
   endtask

   // Called right after a negedge; returns at the negedge where tw_valid rises.
   task automatic start_seq(input logic [1:0] s, input logic [7:0] p);
      int lat;
      push_seq(s, p);
      start  = 1'b1;
      stage  = s;
      passes = p;
      @(negedge clk);
      start  = 1'b0;
      stage  = ~s;
      passes = 8'hFF;
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("rom_addr_first", 64'(rom_addr), 64'({s, 2'b00}));
      lat = 0;
      while (!tw_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk("first_valid_latency", 64'(lat), 64'(2));
   endtask

   task automatic wait_done(input int budget);
      int n;
      int c0;
      n  = 0;
      c0 = done_cnt;
      while (done_cnt == c0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done_cnt == c0) begin
         errors++;
         $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", budget);
      end
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
      chk({tag, "_tw_ri"}, {32'h0, tw_r, tw_i}, 64'(0));
      chk({tag, "_ctl"}, 64'({tw_k, tw_last, tw_valid, busy, done}), 64'(0));
   endtask

   // Monitor: checks every accepted twiddle and the done/busy timing.
   initial begin
      logic last_acc_prev;
      logic exp_done;
      tw_t  e;
      last_acc_prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         exp_done = last_acc_prev;
         if (exp_done || done) begin
            chk("done_pulse", 64'(done), 64'(exp_done));
            if (exp_done) chk("busy_clear_with_done", 64'(busy), 64'(0));
         end
         if (done) done_cnt++;
         if (tw_valid && tw_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_twiddle: got r=%h i=%h k=%0d expected none",
                        tw_r, tw_i, tw_k);
            end else begin
               e = sb.pop_front();
               chk("twiddle", 64'({tw_r, tw_i, tw_k, tw_last}), 64'(e));
            end
         end
         last_acc_prev = tw_valid && tw_ready && tw_last;
      end
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      stage    = 2'd0;
      passes   = 8'd0;
      tw_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("post_reset_idle");

      // Stage 2, single pass.
      start_seq(2'd2, 8'd0);
      wait_done(40);

      // Stage 1, two passes.
      start_seq(2'd1, 8'd1);
      wait_done(60);

      // Output stall for 5 cycles on the first twiddle.
      tw_ready = 1'b0;
      start_seq(2'd2, 8'd0);
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid_held", 64'(tw_valid), 64'(1));
         chk("stall_data_held", 64'({tw_r, tw_i, tw_k}), 64'({16'h7FFF, 16'h0000, 2'd0}));
         @(negedge clk);
      end
      tw_ready = 1'b1;
      wait_done(40);

      // Second start mid-sequence must be ignored.
      start_seq(2'd2, 8'd0);
      start  = 1'b1;
      stage  = 2'd1;
      passes = 8'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(40);
      repeat (10) @(negedge clk);
      chk("no_extra_sequence", 64'({tw_valid, busy}), 64'(0));

      // Asynchronous reset while stalled in LOAD with tw_valid high.
      tw_ready = 1'b0;
      start_seq(2'd2, 8'd0);
      @(negedge clk);
      chk("pre_reset_valid", 64'(tw_valid), 64'(1));
      #3 rst = 1'b1;
      #1 chk_all_zero("async_reset");
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      tw_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_resume", 64'({tw_valid, busy, rom_addr}), 64'(0));
      start_seq(2'd3, 8'd0);
      wait_done(40);

      // Maximum pass count: 1024 twiddles.
      start_seq(2'd0, 8'd255);
      wait_done(3000);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
